// File: rtl/sm_register.sv
// ---------------------------------------------------------------------------
// sm_register
//
// Generic edge-triggered storage register. This is the basic state element of
// the design. It captures d on every rising clock edge. It loads RESET_VALUE
// as soon as rst_n goes low, without waiting for a clock edge.
//
// Parameters:
//   WIDTH        - data width in bits. Narrower nets connect through the LSBs.
//   RESET_VALUE  - value held on q while rst_n is low.
//
// Ports (this order is fixed so that positional instantiation works):
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   d      in   WIDTH  next-state data
//   q      out  WIDTH  registered value
//
// Feeding d from ~q with WIDTH = 1 makes a divide-by-2 toggle. The VGA debug
// top level uses this arrangement to produce the pixel-enable strobe.
// ---------------------------------------------------------------------------
module sm_register #(
  parameter int unsigned           WIDTH       = 32,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reset assertion acts immediately. Release takes effect at the first
  // rising edge where rst_n is already high, so the integration must
  // deassert rst_n synchronously to clk. Data passes through bit-for-bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VALUE;
    end else begin
      q <= d;
    end
  end

endmodule

// File: tb/tb_sm_register.sv
// ---------------------------------------------------------------------------
// tb_sm_register
//
// Self-checking bench for sm_register. It uses three instances:
//   - dut32 : default 32-bit register with a reset value of 0
//   - dut8  : WIDTH = 8 with RESET_VALUE = 8'h3C
//   - tog   : WIDTH = 1, wired as d = ~q to form a divide-by-2 toggle
// Inputs are driven on the falling edge of clk. Outputs are sampled 1 ns after
// the rising edge, or at mid-cycle points away from the active edge.
// ---------------------------------------------------------------------------
module tb_sm_register;

  localparam logic [7:0] P8_RESET = 8'h3C;

  logic        clk;
  logic        rst_n;
  logic [31:0] d;
  logic [31:0] q;

  logic        rst_n8;
  logic [7:0]  d8;
  logic [7:0]  q8;

  logic        rst_n_tog;
  logic        tog_q;
  logic        tog_d;

  int checks;
  int errors;
  int q_changes;

  typedef struct {
    logic        rst_n;
    logic [31:0] d;
    logic [31:0] q_exp;
    string       name;
  } vec_t;

  vec_t vecs[6];

  assign tog_d = ~tog_q;

  sm_register dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (d),
    .q     (q)
  );

  sm_register #(
    .WIDTH       (8),
    .RESET_VALUE (P8_RESET)
  ) dut8 (
    .clk   (clk),
    .rst_n (rst_n8),
    .d     (d8),
    .q     (q8)
  );

  sm_register #(
    .WIDTH       (1),
    .RESET_VALUE (1'b0)
  ) tog (
    .clk   (clk),
    .rst_n (rst_n_tog),
    .d     (tog_d),
    .q     (tog_q)
  );

  // Free-running clock with a 10 ns period. Rising edges occur at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count every change on q. The hold test uses this count to show that q
  // does not glitch while d stays constant.
  always @(q) q_changes++;

  // Drive one vector on the falling edge, then move to just after the next
  // rising edge so the caller can sample q.
  task automatic applyStimulus(input logic rst_v, input logic [31:0] d_v);
    @(negedge clk);
    rst_n = rst_v;
    d     = d_v;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  initial begin
    logic [31:0] model_q;
    logic        r;
    logic [31:0] dv;
    int          base;

    checks    = 0;
    errors    = 0;
    q_changes = 0;
    rst_n     = 1'b0;
    rst_n8    = 1'b0;
    rst_n_tog = 1'b0;
    d         = 32'hFFFF_FFFF;
    d8        = 8'hFF;

    // Directed vectors: reset hold, two captures, and the A5 load used by
    // the async-reset sequence below.
    vecs[0] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0000, "reset_hold_1"};
    vecs[1] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0000, "reset_hold_2"};
    vecs[2] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0000, "reset_hold_3"};
    vecs[3] = '{1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "capture_1"};
    vecs[4] = '{1'b1, 32'h1234_5678, 32'h1234_5678, "capture_2"};
    vecs[5] = '{1'b1, 32'hA5A5_A5A5, 32'hA5A5_A5A5, "load_a5"};

    $display("[TB] directed vectors");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].d);
      checkOutput(vecs[i].name, q, vecs[i].q_exp);
      // After a capture, change d mid-cycle. q must not follow it before
      // the next edge.
      if (vecs[i].rst_n) begin
        d = ~vecs[i].d;
        #2;
        checkOutput({vecs[i].name, "_stable"}, q, vecs[i].q_exp);
        d = vecs[i].d;
      end
    end

    // Asynchronous reset asserted midway between edges while q holds A5A5A5A5.
    $display("[TB] async reset");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("async_assert", q, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("async_hold", q, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    d     = 32'h600D_F00D;
    #1;
    checkOutput("release_no_capture", q, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("release_first_capture", q, 32'h600D_F00D);

    // Parameter check. dut8 has been held in reset since time zero.
    $display("[TB] parameter check");
    @(negedge clk);
    checkOutput("p8_reset_value", {24'h0, q8}, {24'h0, P8_RESET});
    rst_n8 = 1'b1;
    d8     = 8'h81;
    #1;
    checkOutput("p8_release_no_capture", {24'h0, q8}, {24'h0, P8_RESET});
    @(posedge clk);
    #1;
    checkOutput("p8_capture", {24'h0, q8}, 32'h81);

    // Toggle divider. After release, q reads 1,0,1,0,1,0 over edges 1..6.
    $display("[TB] toggle divider");
    @(negedge clk);
    checkOutput("tog_reset", {31'h0, tog_q}, 32'h0);
    rst_n_tog = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("tog_edge_%0d", e), {31'h0, tog_q}, 32'(e % 2));
    end

    // Hold d constant for 10 edges. q must never change during the window.
    $display("[TB] hold");
    applyStimulus(1'b1, 32'h0F0F_0F0F);
    checkOutput("hold_load", q, 32'h0F0F_0F0F);
    base = q_changes;
    for (int e = 0; e < 10; e++) begin
      applyStimulus(1'b1, 32'h0F0F_0F0F);
      checkOutput("hold_value", q, 32'h0F0F_0F0F);
    end
    checkOutput("hold_no_glitch", 32'(q_changes - base), 32'h0);

    // Random stimulus against a behavioural model. Whatever was presented
    // during a cycle with reset high is what the register shows after the
    // edge. A cycle with reset low shows the reset value.
    $display("[TB] random stimulus");
    for (int n = 0; n < 200; n++) begin
      r  = ($urandom_range(0, 7) != 0);
      dv = $urandom;
      model_q = r ? dv : 32'h0;
      applyStimulus(r, dv);
      checkOutput("random", q, model_q);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
